// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state type and instruction field-offset helpers for
// the instruction sequencer.
package ctrl_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_NONE    = 5'b00000;
  localparam logic [OP_W-1:0] OP_MAC     = 5'b00001;
  localparam logic [OP_W-1:0] OP_SEND_WT = 5'b00010;
  localparam logic [OP_W-1:0] OP_STORE   = 5'b00011;
  localparam logic [OP_W-1:0] OP_RX_INP  = 5'b00100;
  localparam logic [OP_W-1:0] OP_RX_WT   = 5'b00101;
  localparam logic [OP_W-1:0] OP_TX_OUT  = 5'b00110;
  localparam logic [OP_W-1:0] OP_NOP     = 5'b11111;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Field MSB positions: opcode on top, then address, data, len.
  function automatic int unsigned addr_msb(input int unsigned instr_w);
    return instr_w - OP_W - 1;
  endfunction

  function automatic int unsigned data_msb(input int unsigned instr_w,
                                           input int unsigned addr_w);
    return instr_w - OP_W - addr_w - 1;
  endfunction

  function automatic int unsigned len_msb(input int unsigned instr_w,
                                          input int unsigned addr_w,
                                          input int unsigned data_w);
    return instr_w - OP_W - addr_w - data_w - 1;
  endfunction

  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    case (op)
      OP_NONE, OP_MAC, OP_SEND_WT, OP_STORE,
      OP_RX_INP, OP_RX_WT, OP_TX_OUT, OP_NOP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_burst_op(input logic [OP_W-1:0] op);
    return (op == OP_MAC) || (op == OP_SEND_WT) || (op == OP_TX_OUT);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host instruction handshake.
//   instr_valid : host has an instruction on instr
//   instr_ready : sequencer accepts instr this cycle
//   instr       : opcode / address / data / len / reserved
interface instr_sequencer_if #(
  parameter int unsigned INSTR_W = 64
) ();

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/burst_addr_gen.sv
// Burst address generator: holds the next beat address and the count of
// beats still to issue.
//   load      : capture base (beat 0 issued elsewhere) and total length len (>=2)
//   advance   : one burst beat issued this cycle
//   addr      : address of the next beat (wraps modulo 2^ADDR_W)
//   done      : the next beat is the last one
module burst_addr_gen #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (load) begin
      addr      <= base_addr + ADDR_W'(1);
      remaining <= len - LEN_W'(1);
      done      <= (len == LEN_W'(2));
    end else if (advance && (remaining != '0)) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
      done      <= (remaining == LEN_W'(2));
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction decoder and burst sequencer for the systolic-array datapath.
//   clk, rst          : clock, synchronous active-high reset
//   host (slave)      : instr_valid / instr_ready / instr handshake
//   inp_buf_*         : input-buffer write/read strobes, address, write data
//   wt_buf_*          : weight-buffer write/read strobes, address, write data
//   acc_result_to_op_buf, acc_to_op_buf_addr : store accumulator result
//   op_buf_ready      : output buffer can take a send request
//   op_buffer_instr_for_sending_data, out_buf_addr : transmit strobe/source
//   busy              : burst in progress
//   err_illegal       : sticky unknown-opcode flag
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W    = 64,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OUT_ADDR_W = 4,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_sequencer_if.slave      host,
  output logic                  inp_buf_we,
  output logic                  inp_buf_re,
  output logic [ADDR_W-1:0]     inp_buf_addr,
  output logic [DATA_W-1:0]     inp_buf_data,
  output logic                  wt_buf_we,
  output logic                  wt_buf_re,
  output logic [ADDR_W-1:0]     wt_buf_addr,
  output logic [DATA_W-1:0]     wt_buf_data,
  output logic                  acc_result_to_op_buf,
  output logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr,
  input  logic                  op_buf_ready,
  output logic                  op_buffer_instr_for_sending_data,
  output logic [OUT_ADDR_W-1:0] out_buf_addr,
  output logic                  busy,
  output logic                  err_illegal
);

  localparam int unsigned ADDR_MSB = addr_msb(INSTR_W);
  localparam int unsigned DATA_MSB = data_msb(INSTR_W, ADDR_W);
  localparam int unsigned LEN_MSB  = len_msb(INSTR_W, ADDR_W, DATA_W);

  state_e            state;
  logic [OP_W-1:0]   op_q;

  logic [OP_W-1:0]   dec_op;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_data;
  logic [LEN_W-1:0]  dec_len;
  logic [LEN_W-1:0]  len_eff;

  logic              accept;
  logic              load;
  logic              advance;
  logic              gen_done;
  logic [ADDR_W-1:0] gen_addr;

  logic              fire;
  logic [OP_W-1:0]   beat_op;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_data;

  // Reserved instruction bits are intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^host.instr;

  assign host.instr_ready = (state == IDLE) && op_buf_ready && !rst;
  assign busy             = (state == BURST);

  assign dec_op   = host.instr[INSTR_W-1 -: OP_W];
  assign dec_addr = host.instr[ADDR_MSB -: ADDR_W];
  assign dec_data = host.instr[DATA_MSB -: DATA_W];
  assign dec_len  = host.instr[LEN_MSB -: LEN_W];
  assign len_eff  = (dec_len == '0) ? LEN_W'(1) : dec_len;

  assign accept  = host.instr_valid && host.instr_ready;
  assign load    = accept && is_burst_op(dec_op) && (len_eff != LEN_W'(1));
  // Transmit beats stall while the output buffer is not ready.
  assign advance = (state == BURST) && ((op_q != OP_TX_OUT) || op_buf_ready);

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .base_addr (dec_addr),
    .len       (len_eff),
    .addr      (gen_addr),
    .done      (gen_done)
  );

  // Select what the next beat carries: freshly decoded or burst continuation.
  always_comb begin
    fire      = 1'b0;
    beat_op   = op_q;
    beat_addr = gen_addr;
    beat_data = '0;
    if (accept) begin
      fire      = 1'b1;
      beat_op   = dec_op;
      beat_addr = dec_addr;
      beat_data = dec_data;
    end else if (advance) begin
      fire      = 1'b1;
    end
  end

  // State, opcode latch, sticky error and registered one-cycle strobes.
  always_ff @(posedge clk) begin
    inp_buf_we                       <= 1'b0;
    inp_buf_re                       <= 1'b0;
    inp_buf_addr                     <= '0;
    inp_buf_data                     <= '0;
    wt_buf_we                        <= 1'b0;
    wt_buf_re                        <= 1'b0;
    wt_buf_addr                      <= '0;
    wt_buf_data                      <= '0;
    acc_result_to_op_buf             <= 1'b0;
    acc_to_op_buf_addr               <= '0;
    op_buffer_instr_for_sending_data <= 1'b0;
    out_buf_addr                     <= '0;
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      err_illegal <= 1'b0;
    end else begin
      if (fire) begin
        case (beat_op)
          OP_MAC: begin
            inp_buf_re   <= 1'b1;
            inp_buf_addr <= beat_addr;
          end
          OP_SEND_WT: begin
            wt_buf_re   <= 1'b1;
            wt_buf_addr <= beat_addr;
          end
          OP_STORE: begin
            acc_result_to_op_buf <= 1'b1;
            acc_to_op_buf_addr   <= beat_addr[OUT_ADDR_W-1:0];
          end
          OP_RX_INP: begin
            inp_buf_we   <= 1'b1;
            inp_buf_addr <= beat_addr;
            inp_buf_data <= beat_data;
          end
          OP_RX_WT: begin
            wt_buf_we   <= 1'b1;
            wt_buf_addr <= beat_addr;
            wt_buf_data <= beat_data;
          end
          OP_TX_OUT: begin
            op_buffer_instr_for_sending_data <= 1'b1;
            out_buf_addr                     <= beat_addr[OUT_ADDR_W-1:0];
          end
          default: ;
        endcase
      end
      if (accept) begin
        if (load) begin
          state <= BURST;
          op_q  <= dec_op;
        end
        if (!is_known_op(dec_op)) err_illegal <= 1'b1;
      end else if (advance && gen_done) begin
        state <= IDLE;
      end
    end
  end

endmodule
